netlist_bist: RTL and testbench

Built-in self-test controller for the team's small combinational gate-level netlists: it is the stimulus/response end of a netlist's primary-input/primary-output interface. On `start_i` it drives every input pattern exhaustively onto the netlist's PIs. After a settle interval per pattern, it samples the POs and compacts them into a multiple-input signature register (MISR). At the end it compares the signature with a golden value and reports pass/fail. It sits beside the netlist under test (CUT) in the equivalence/regression harness, so an enhanced netlist (buffered, resized) can be checked against its original golden signature.

---
 rtl/netlist_bist_pkg.sv | 7 +
 rtl/bist_misr.sv | 23 ++
 rtl/netlist_bist.sv | 88 ++++++++
 tb/tb_netlist_bist.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/netlist_bist_pkg.sv
// netlist_bist_pkg: shared FSM state type and default MISR taps/golden signature
// for the 2-input / 3-output CUT.
package netlist_bist_pkg;
  typedef enum logic [1:0] {IDLE, APPLY, CAPTURE, CHECK} state_e;
  localparam logic [2:0] POLY_DEF   = 3'b010;
  localparam logic [2:0] GOLDEN_DEF = 3'b101;
endpackage

// File: rtl/bist_misr.sv
// bist_misr: multiple-input signature register; shifts left with MSB feedback
// into the LSB and the tap mask, then folds in the captured response.
module bist_misr #(
  parameter int W = 3,
  parameter logic [W-1:0] TAPS = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] sig_o
);
  logic [W-1:0] sig_q, sig_d;
  logic         fb;
  assign fb    = sig_q[W-1];
  assign sig_d = {sig_q[W-2:0], fb} ^ data_i ^ (fb ? TAPS : '0);
  assign sig_o = sig_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sig_q <= '0;
    else if (clr_i) sig_q <= '0;
    else if (en_i) sig_q <= sig_d;
endmodule

// File: rtl/netlist_bist.sv
// netlist_bist: exhaustive-pattern BIST controller with MISR compaction and golden compare.
// Define NETLIST_BIST_SIG_OUT_EN to expose the live signature on sig_o.
module netlist_bist
  import netlist_bist_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int N_OUT = 3,
  parameter int SETTLE = 2,
  parameter logic [N_OUT-1:0] POLY = POLY_DEF,
  parameter logic [N_OUT-1:0] GOLDEN = GOLDEN_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  output logic [N_IN-1:0]  stim_o,
  input  logic [N_OUT-1:0] resp_i,
  output logic             busy_o,
  output logic             done_o,
`ifdef NETLIST_BIST_SIG_OUT_EN
  output logic             pass_o,
  output logic [N_OUT-1:0] sig_o
`else
  output logic             pass_o
`endif
);
  localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  // One extra counter bit keeps the terminal compare from aliasing on wrap.
  localparam logic [N_IN:0] LAST = (N_IN+1)'((1 << N_IN) - 1);
  state_e          state_q;
  logic [N_IN:0]   pat_q;
  logic [SW-1:0]   set_q;
  logic [N_IN-1:0] stim_q;
  logic            busy_q, done_q, pass_q;
  logic [N_OUT-1:0] sig;
  bist_misr #(.W(N_OUT), .TAPS(POLY)) u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (state_q == IDLE && start_i),
    .en_i   (state_q == CAPTURE),
    .data_i (resp_i),
    .sig_o  (sig)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      pat_q   <= '0;
      set_q   <= '0;
      stim_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          state_q <= APPLY;
          pat_q   <= '0;
          set_q   <= '0;
          stim_q  <= '0;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
        APPLY: begin
          state_q <= set_q == SW'(SETTLE - 1) ? CAPTURE : APPLY;
          set_q   <= set_q == SW'(SETTLE - 1) ? '0 : set_q + 1'b1;
        end
        CAPTURE: begin
          state_q <= pat_q == LAST ? CHECK : APPLY;
          pat_q   <= pat_q == LAST ? pat_q : pat_q + 1'b1;
          stim_q  <= pat_q == LAST ? '0 : N_IN'(pat_q + 1'b1);
        end
        CHECK: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          pass_q  <= sig == GOLDEN;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign stim_o = stim_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign pass_o = pass_q;
`ifdef NETLIST_BIST_SIG_OUT_EN
  assign sig_o = sig;
`endif
endmodule

// File: tb/tb_netlist_bist.sv
// tb_netlist_bist: vector table plus randomized CUT tables checked against a
// pattern-loop signature model; covers reset, busy start, held start, SETTLE=1.
module tb_netlist_bist;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, start1 = 1'b0;
  logic [1:0] stim, stim1;
  logic [2:0] resp, resp1, sig, sig1;
  logic busy, done, pass, busy1, done1, pass1;
  logic [3:0][2:0] cur_tab;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  assign resp  = cur_tab[stim];
  assign resp1 = cur_tab[stim1];
  netlist_bist dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .stim_o(stim), .resp_i(resp),
    .busy_o(busy), .done_o(done),
`ifdef NETLIST_BIST_SIG_OUT_EN
    .pass_o(pass), .sig_o(sig)
`else
    .pass_o(pass)
`endif
  );
  netlist_bist #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start1), .stim_o(stim1), .resp_i(resp1),
    .busy_o(busy1), .done_o(done1),
`ifdef NETLIST_BIST_SIG_OUT_EN
    .pass_o(pass1), .sig_o(sig1)
`else
    .pass_o(pass1)
`endif
  );
`ifndef NETLIST_BIST_SIG_OUT_EN
  assign sig  = 3'b000;
  assign sig1 = 3'b000;
`endif
  typedef struct packed {
    logic [3:0][2:0] tab;
    logic [2:0]      sig;
    logic            pass;
  } vec_t;
  vec_t vecs [4];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [2:0] model_sig(input logic [3:0][2:0] tab);
    logic [2:0] s = 3'b000;
    for (int p = 0; p < 4; p++)
      s = {s[1:0], s[2]} ^ tab[p] ^ (s[2] ? 3'b010 : 3'b000);
    return s;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // One full run on the SETTLE=2 instance; optional stray starts at cycles 4 and 8.
  task automatic run(input logic [3:0][2:0] tab, input logic [2:0] esig, input logic epass,
                     input bit stray);
    cur_tab = tab;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 0; e < 13; e++) begin
      if (e < 12) check("stim_seq", 32'(stim), 32'(e / 3));
      check("busy_run", 32'(busy), 32'd1);
      check("done_early", 32'(done), 32'd0);
      start = stray && (e == 4 || e == 8);
      tick();
    end
    start = 1'b0;
    check("done_edge13", 32'(done), 32'd1);
    check("busy_fall", 32'(busy), 32'd0);
    check("pass", 32'(pass), 32'(epass));
`ifdef NETLIST_BIST_SIG_OUT_EN
    check("sig", 32'(sig), 32'(esig));
`else
    if (esig != esig) check("sig_unused", 32'(esig), 32'(esig));
`endif
    tick();
    check("done_sticky", 32'(done), 32'd1);
  endtask
  initial begin
    logic [3:0][2:0] t;
    logic [2:0] es;
    vecs[0] = '{tab: {3'b011, 3'b111, 3'b111, 3'b111}, sig: 3'b101, pass: 1'b1};
    vecs[1] = '{tab: {3'b111, 3'b111, 3'b111, 3'b111}, sig: 3'b001, pass: 1'b0};
    vecs[2] = '{tab: {3'b000, 3'b000, 3'b000, 3'b000}, sig: 3'b000, pass: 1'b0};
    vecs[3] = '{tab: {3'b000, 3'b100, 3'b010, 3'b001}, sig: 3'b011, pass: 1'b0};
    cur_tab = '0;
    #12;
    check("rst_stim", 32'(stim), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) run(vecs[i].tab, vecs[i].sig, vecs[i].pass, 1'b0);
    // stray starts while busy must not disturb a run
    run(vecs[0].tab, 3'b101, 1'b1, 1'b1);
    // reset during the third pattern's APPLY
    cur_tab = vecs[0].tab;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 0; e < 6; e++) tick();
    check("mid_stim", 32'(stim), 32'd2);
    rst_n = 1'b0;
    #1;
    check("arst_stim", 32'(stim), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_pass", 32'(pass), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int e = 0; e < 16; e++) begin
      tick();
      check("post_rst_idle", 32'({busy, done, stim}), 32'd0);
    end
    // held start: back-to-back runs with one IDLE cycle between them
    cur_tab = vecs[0].tab;
    start = 1'b1;
    for (int e = 0; e < 28; e++) begin
      tick();
      if (e == 13) check("held_done1", 32'({done, pass, busy}), 32'b110);
      if (e == 14) check("held_restart", 32'({done, pass, busy}), 32'b001);
      if (e == 26) check("held_not_yet", 32'(done), 32'd0);
      if (e == 27) check("held_done2", 32'({done, pass, busy}), 32'b110);
    end
    start = 1'b0;
    tick();
    tick();
    // SETTLE=1 instance: 2 cycles per pattern, done after edge 9
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int e = 0; e < 9; e++) begin
      if (e < 8) check("s1_stim", 32'(stim1), 32'(e / 2));
      check("s1_done_early", 32'(done1), 32'd0);
      tick();
    end
    check("s1_done", 32'({done1, pass1, busy1}), 32'b110);
    // randomized CUT tables against the signature model
    for (int r = 0; r < 20; r++) begin
      t = 12'($urandom);
      if (r % 5 == 0) t = vecs[0].tab;
      es = model_sig(t);
      run(t, es, es == 3'b101, r[0]);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
